// File: rtl/obj_ram_sequencer.sv
// obj_ram_sequencer: sole initiator for the 64x8 object RAM.
// DMA copies 64 source bytes into the RAM; SCAN reads the RAM back as
// 16 four-byte sprite records and strobes each one to the line engine.
module obj_ram_sequencer #(
  parameter int unsigned SRC_AW      = 10,
  parameter bit          REC_SKIP_Y0 = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dma_start,
  input  logic [SRC_AW-1:0] dma_base,
  output logic [SRC_AW-1:0] src_addr,
  input  logic [7:0]        src_data,
  input  logic              scan_start,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_wre,
  output logic [5:0]        ram_ad,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout,
  output logic              obj_valid,
  output logic [3:0]        obj_index,
  output logic [7:0]        obj_y,
  output logic [7:0]        obj_code,
  output logic [7:0]        obj_attr,
  output logic [7:0]        obj_x,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_DMA, S_SCAN, S_DONE} state_t;

  state_t     state;
  logic [6:0] cnt;
  logic [7:0] byte0;
  logic [7:0] byte1;
  logic [7:0] byte2;
  logic [5:0] slot_idx;

  // Byte whose read data is on ram_dout during scan cycle cnt (cnt=1..64);
  // the 6-bit wrap maps cnt=64 onto byte 63.
  assign slot_idx = cnt[5:0] - 6'd1;

  // Source data arrives one cycle after src_addr, which is exactly the cycle
  // its RAM write is issued, so write data is passed straight through.
  assign ram_din = ram_wre ? src_data : '0;

  // Sequencer FSM with all control and record outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      byte0     <= '0;
      byte1     <= '0;
      byte2     <= '0;
      src_addr  <= '0;
      ram_ce    <= 1'b0;
      ram_oce   <= 1'b0;
      ram_wre   <= 1'b0;
      ram_ad    <= '0;
      obj_valid <= 1'b0;
      obj_index <= '0;
      obj_y     <= '0;
      obj_code  <= '0;
      obj_attr  <= '0;
      obj_x     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done      <= 1'b0;
      obj_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dma_start) begin
            state    <= S_DMA;
            busy     <= 1'b1;
            src_addr <= dma_base;
            cnt      <= '0;
          end else if (scan_start) begin
            state   <= S_SCAN;
            busy    <= 1'b1;
            ram_ce  <= 1'b1;
            ram_oce <= 1'b1;
            ram_ad  <= '0;
            cnt     <= '0;
          end
        end
        S_DMA: begin
          if (cnt == 7'd64) begin
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            ram_ce  <= 1'b0;
            ram_wre <= 1'b0;
            ram_ad  <= '0;
            cnt     <= '0;
          end else begin
            src_addr <= src_addr + SRC_AW'(1);
            ram_ce   <= 1'b1;
            ram_wre  <= 1'b1;
            ram_ad   <= cnt[5:0];
            cnt      <= cnt + 7'd1;
          end
        end
        S_SCAN: begin
          if (cnt != 7'd0 && cnt <= 7'd64) begin
            case (slot_idx[1:0])
              2'd0: byte0 <= ram_dout;
              2'd1: byte1 <= ram_dout;
              2'd2: byte2 <= ram_dout;
              default: begin
                if (!(REC_SKIP_Y0 && byte0 == 8'h00)) begin
                  obj_valid <= 1'b1;
                  obj_index <= slot_idx[5:2];
                  obj_y     <= byte0;
                  obj_code  <= byte1;
                  obj_attr  <= byte2;
                  obj_x     <= ram_dout;
                end
              end
            endcase
          end
          if (cnt == 7'd65) begin
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            ram_ce  <= 1'b0;
            ram_oce <= 1'b0;
            ram_ad  <= '0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 7'd1;
            if (cnt < 7'd63) ram_ad <= cnt[5:0] + 6'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obj_ram_sequencer.sv
// Directed bench for obj_ram_sequencer: two instances (record skip on/off)
// share all stimulus, each with its own RAM and source memory model.
module tb_obj_ram_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       dma_start = 1'b0;
  logic       scan_start = 1'b0;
  logic [9:0] dma_base = '0;

  always #5 clk = ~clk;

  logic [9:0] src_addr_a, src_addr_b;
  logic [7:0] src_data_a, src_data_b;
  logic       ram_ce_a, ram_oce_a, ram_wre_a, ram_ce_b, ram_oce_b, ram_wre_b;
  logic [5:0] ram_ad_a, ram_ad_b;
  logic [7:0] ram_din_a, ram_din_b, ram_dout_a, ram_dout_b;
  logic       obj_valid_a, obj_valid_b, busy_a, busy_b, done_a, done_b;
  logic [3:0] obj_index_a, obj_index_b;
  logic [7:0] obj_y_a, obj_code_a, obj_attr_a, obj_x_a;
  logic [7:0] obj_y_b, obj_code_b, obj_attr_b, obj_x_b;

  obj_ram_sequencer #(.SRC_AW(10), .REC_SKIP_Y0(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .dma_start(dma_start), .dma_base(dma_base),
    .src_addr(src_addr_a), .src_data(src_data_a), .scan_start(scan_start),
    .ram_ce(ram_ce_a), .ram_oce(ram_oce_a), .ram_wre(ram_wre_a),
    .ram_ad(ram_ad_a), .ram_din(ram_din_a), .ram_dout(ram_dout_a),
    .obj_valid(obj_valid_a), .obj_index(obj_index_a), .obj_y(obj_y_a),
    .obj_code(obj_code_a), .obj_attr(obj_attr_a), .obj_x(obj_x_a),
    .busy(busy_a), .done(done_a)
  );

  obj_ram_sequencer #(.SRC_AW(10), .REC_SKIP_Y0(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .dma_start(dma_start), .dma_base(dma_base),
    .src_addr(src_addr_b), .src_data(src_data_b), .scan_start(scan_start),
    .ram_ce(ram_ce_b), .ram_oce(ram_oce_b), .ram_wre(ram_wre_b),
    .ram_ad(ram_ad_b), .ram_din(ram_din_b), .ram_dout(ram_dout_b),
    .obj_valid(obj_valid_b), .obj_index(obj_index_b), .obj_y(obj_y_b),
    .obj_code(obj_code_b), .obj_attr(obj_attr_b), .obj_x(obj_x_b),
    .busy(busy_b), .done(done_b)
  );

  logic [7:0] mem_a [64];
  logic [7:0] mem_b [64];
  logic [7:0] pre_img [64];
  logic [7:0] exp_img [64];
  logic       preload = 1'b0;
  logic [63:0] snap_a, snap_b;
  int n_cmp = 0;
  int n_err = 0;

  // RAM and source memory models: sync write, 1-cycle read, backdoor preload.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) begin
        mem_a[i] <= pre_img[i];
        mem_b[i] <= pre_img[i];
      end
    end else begin
      if (ram_ce_a && ram_wre_a) mem_a[ram_ad_a] <= ram_din_a;
      else if (ram_ce_a && ram_oce_a) ram_dout_a <= mem_a[ram_ad_a];
      if (ram_ce_b && ram_wre_b) mem_b[ram_ad_b] <= ram_din_b;
      else if (ram_ce_b && ram_oce_b) ram_dout_b <= mem_b[ram_ad_b];
    end
    src_data_a <= src_addr_a[7:0] ^ 8'hA5;
    src_data_b <= src_addr_b[7:0] ^ 8'hA5;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_ram();
    for (int i = 0; i < 64; i++) exp_img[i] = pre_img[i];
    @(negedge clk); preload = 1'b1;
    @(negedge clk); preload = 1'b0;
  endtask

  task automatic run_dma(input logic [9:0] base, input bit glitch, input int abort_t);
    logic [9:0] ea;
    @(negedge clk);
    dma_start = 1'b1; dma_base = base; scan_start = glitch;
    for (int t = 1; t <= 66; t++) begin
      @(negedge clk);
      dma_start = 1'b0;
      scan_start = glitch && (t == 30 || t == 66);
      if (t == abort_t) begin
        chk("abort_pre_wre", 64'(ram_wre_a), 64'(1));
        reset_n = 1'b0;
        #1;
        chk("abort_wre", 64'(ram_wre_a), 64'(0));
        chk("abort_busy", 64'(busy_a), 64'(0));
        chk("abort_ce", 64'(ram_ce_a), 64'(0));
        @(negedge clk); reset_n = 1'b1;
        return;
      end
      chk("dma_busy", 64'(busy_a), 64'(t <= 65));
      chk("dma_done", 64'(done_a), 64'(t == 66));
      chk("dma_wre", 64'(ram_wre_a), 64'(t >= 2 && t <= 65));
      if (t <= 64) begin
        ea = base + 10'(t - 1);
        chk("dma_src_addr", 64'(src_addr_a), 64'(ea));
      end
      if (t >= 2 && t <= 65) begin
        ea = base + 10'(t - 2);
        chk("dma_wr", 64'({ram_ad_a, ram_din_a}), 64'({6'(t - 2), ea[7:0] ^ 8'hA5}));
      end
    end
    if (glitch) begin
      @(negedge clk); scan_start = 1'b0;
    end
    for (int i = 0; i < 64; i++) begin
      ea = base + 10'(i);
      exp_img[i] = ea[7:0] ^ 8'hA5;
      chk("dma_image", 64'(mem_a[i]), 64'(exp_img[i]));
    end
  endtask

  task automatic run_scan();
    bit exp_v;
    int n;
    logic [63:0] rec;
    @(negedge clk); scan_start = 1'b1;
    for (int j = 0; j <= 66; j++) begin
      @(negedge clk);
      scan_start = 1'b0;
      exp_v = (j >= 5 && j <= 65 && (j % 4) == 1);
      n = exp_v ? (j - 5) / 4 : 0;
      rec = 64'({4'(n), exp_img[4*n], exp_img[4*n+1], exp_img[4*n+2], exp_img[4*n+3]});
      chk("scan_valid_a", 64'(obj_valid_a), 64'(exp_v && exp_img[4*n] != 8'h00));
      chk("scan_valid_b", 64'(obj_valid_b), 64'(exp_v));
      if (exp_v && exp_img[4*n] != 8'h00)
        chk("scan_rec_a", 64'({obj_index_a, obj_y_a, obj_code_a, obj_attr_a, obj_x_a}), rec);
      if (exp_v)
        chk("scan_rec_b", 64'({obj_index_b, obj_y_b, obj_code_b, obj_attr_b, obj_x_b}), rec);
      chk("scan_busy", 64'(busy_a), 64'(j <= 65));
      chk("scan_done", 64'(done_a), 64'(j == 66));
      chk("scan_ctl", 64'({ram_ce_a, ram_oce_a, ram_wre_a}), j <= 65 ? 64'(3'b110) : 64'(3'b000));
      if (j == 13) begin
        snap_a = 64'({obj_valid_a, obj_index_a, obj_y_a, obj_code_a, obj_attr_a, obj_x_a});
        snap_b = 64'({obj_valid_b, obj_index_b, obj_y_b, obj_code_b, obj_attr_b, obj_x_b});
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_ctl", 64'({busy_a, done_a, ram_ce_a, ram_oce_a, ram_wre_a, obj_valid_a}), 64'(0));
    chk("reset_bus", 64'({ram_ad_a, ram_din_a, src_addr_a, obj_index_a}), 64'(0));
    chk("reset_obj", 64'({obj_y_a, obj_code_a, obj_attr_a, obj_x_a}), 64'(0));
    reset_n = 1'b1;

    // DMA across the 3FF->000 source address wrap
    run_dma(10'h3F0, 1'b0, 0);

    // Scan of image byte i = i+1
    for (int i = 0; i < 64; i++) pre_img[i] = 8'(i + 1);
    load_ram();
    run_scan();
    chk("rec2_a", snap_a, 64'({1'b1, 4'd2, 32'h090A0B0C}));

    // Record 2 with Y=00: skipped on A (fields hold record 1), emitted on B
    pre_img[8] = 8'h00; pre_img[9] = 8'h44; pre_img[10] = 8'h55; pre_img[11] = 8'h66;
    load_ram();
    run_scan();
    chk("skip_rec2_a", snap_a, 64'({1'b0, 4'd1, 32'h05060708}));
    chk("skip_rec2_b", snap_b, 64'({1'b1, 4'd2, 32'h00445566}));

    // Simultaneous starts, plus scan_start mid-DMA and in DONE: all ignored
    run_dma(10'h2A7, 1'b1, 0);
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      chk("no_scan", 64'({busy_a, obj_valid_a, obj_valid_b}), 64'(0));
    end

    // Reset during DMA cycle 20, then a fresh full DMA
    run_dma(10'h3F0, 1'b0, 21);
    chk("post_abort_idle", 64'({busy_a, ram_wre_a, ram_ce_a}), 64'(0));
    run_dma(10'h055, 1'b0, 0);

    // DMA then SCAN started the cycle after done
    run_dma(10'h120, 1'b0, 0);
    run_scan();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
